// File: rtl/wb_slave_mux_if.sv
// CPU-side and slave-side wishbone signals of the IO-space slave multiplexer.
// Handshake: a cycle is requested by m_cyc&m_stb and ends with exactly one m_ack or m_err pulse.
interface wb_slave_mux_if #(
    parameter int NSLAVES = 6,
    parameter int DW      = 32
);
    logic                  m_cyc;
    logic                  m_stb;
    logic                  m_we;
    logic [DW-1:0]         m_dat_o;
    logic                  m_ack;
    logic                  m_err;
    logic [NSLAVES-1:0]    s_en;
    logic [NSLAVES-1:0]    s_cyc;
    logic [NSLAVES-1:0]    s_stb;
    logic                  s_we;
    logic [NSLAVES*DW-1:0] s_dat_i;
    logic [NSLAVES-1:0]    s_ack;
    logic [NSLAVES-1:0]    s_err;

    modport slave (
        input  m_cyc, m_stb, m_we, s_en, s_dat_i, s_ack, s_err,
        output m_dat_o, m_ack, m_err, s_cyc, s_stb, s_we
    );

    modport master (
        output m_cyc, m_stb, m_we, s_en, s_dat_i, s_ack, s_err,
        input  m_dat_o, m_ack, m_err, s_cyc, s_stb, s_we
    );
endinterface

// File: rtl/wb_slave_mux.sv
// Registered N-slave wishbone interconnect: routes one CPU cycle to the lowest enabled
// slave, auto-acks ack-less slaves, answers unmapped space and times out hung cycles.
module wb_slave_mux #(
    parameter int                  NSLAVES      = 6,
    parameter int                  DW           = 32,
    parameter logic [NSLAVES-1:0]  AUTO_ACK     = '0,
    parameter int                  TIMEOUT      = 63,
    parameter logic [DW-1:0]       DEFAULT_DATA = '1
) (
    input  logic                 clkcpu,
    input  logic                 rst_i,
    wb_slave_mux_if.slave        bus,
    output logic [7:0]           tmo_count,
    output logic [1:0]           dbg_state
);
    localparam int SELW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DFLT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]         state_q, state_d;
    logic [SELW-1:0]    sel_q, sel_d;
    logic               we_q, we_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [7:0]         tmo_q, tmo_d;
    logic [DW-1:0]      dat_q, dat_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic [SELW-1:0]    lowest;
    logic [NSLAVES-1:0] sel_onehot;
    logic               sel_ack;
    logic               sel_err;

    // Descending scan so the lowest set s_en bit is the last assignment and wins.
    always_comb begin
        lowest = '0;
        for (int i = NSLAVES - 1; i >= 0; i--) begin
            if (bus.s_en[i]) lowest = SELW'(i);
        end
    end

    always_comb begin
        sel_onehot        = '0;
        sel_onehot[sel_q] = 1'b1;
    end

    // Ack-less slaves are acked on their second BUSY cycle (counter already at 1).
    assign sel_ack = AUTO_ACK[sel_q] ? (cnt_q == 8'd1) : bus.s_ack[sel_q];
    assign sel_err = bus.s_err[sel_q];

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        dat_d   = dat_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.m_cyc && bus.m_stb) begin
                    we_d    = bus.m_we;
                    sel_d   = lowest;
                    cnt_d   = '0;
                    state_d = (|bus.s_en) ? ST_BUSY : ST_DFLT;
                end
            end
            ST_BUSY: begin
                if (!bus.m_cyc) begin
                    state_d = ST_IDLE;
                end else if (sel_err) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else if (sel_ack) begin
                    ack_d   = 1'b1;
                    if (!we_q) dat_d = bus.s_dat_i[sel_q*DW +: DW];
                    state_d = ST_RESP;
                end else if (cnt_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    if (tmo_q != 8'hFF) tmo_d = tmo_q + 8'd1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DFLT: begin
                ack_d   = 1'b1;
                if (!we_q) dat_d = DEFAULT_DATA;
                state_d = ST_RESP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clkcpu) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            dat_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            dat_q   <= dat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign bus.s_cyc   = (state_q == ST_BUSY) ? sel_onehot : '0;
    assign bus.s_stb   = (state_q == ST_BUSY) ? sel_onehot : '0;
    assign bus.s_we    = we_q;
    assign bus.m_dat_o = dat_q;
    assign bus.m_ack   = ack_q;
    assign bus.m_err   = err_q;
    assign tmo_count   = tmo_q;
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_wb_slave_mux.sv
// Bench for wb_slave_mux: directed cases plus randomized transactions checked against
// a transaction-level model of routing, termination priority, read data and timeout count.
module tb_wb_slave_mux;
  localparam int NS = 6;
  localparam int DW = 32;
  localparam int TMO = 4;
  localparam logic [NS-1:0] AUTO = 6'b000001;
  localparam logic [DW-1:0] DFLT = 32'hFFFF_FFFF;

  logic clkcpu = 1'b0;
  logic rst_i = 1'b1;
  logic [7:0] tmo_count;
  logic [1:0] dbg_state;

  wb_slave_mux_if #(.NSLAVES(NS), .DW(DW)) bus();

  wb_slave_mux #(
    .NSLAVES(NS), .DW(DW), .AUTO_ACK(AUTO), .TIMEOUT(TMO), .DEFAULT_DATA(DFLT)
  ) dut (
    .clkcpu(clkcpu),
    .rst_i(rst_i),
    .bus(bus),
    .tmo_count(tmo_count),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clkcpu = ~clkcpu;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] sd[NS];
  int ack_cyc[NS];
  int err_cyc[NS];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_dat;
  logic [7:0] exp_tmo;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_slaves();
    for (int i = 0; i < NS; i++) begin
      ack_cyc[i] = 0;
      err_cyc[i] = 0;
    end
  endtask

  task automatic drive_slaves(input int c);
    for (int i = 0; i < NS; i++) begin
      bus.s_ack[i] = (ack_cyc[i] == c);
      bus.s_err[i] = (err_cyc[i] == c);
    end
  endtask

  // Transaction-level reference: which slave, in which cycle the response lands, and how.
  task automatic predict(input logic [NS-1:0] en, output int resp, output bit is_err,
                         output bit is_tmo, output int sel);
    sel = -1;
    is_err = 0;
    is_tmo = 0;
    for (int i = 0; i < NS; i++) if (en[i] && sel < 0) sel = i;
    if (sel < 0) begin
      resp = 2;
      return;
    end
    for (int c = 1; c <= TMO; c++) begin
      if (err_cyc[sel] == c) begin
        resp = c + 1;
        is_err = 1;
        return;
      end
      if (AUTO[sel] ? (c == 2) : (ack_cyc[sel] == c)) begin
        resp = c + 1;
        return;
      end
    end
    resp = TMO + 1;
    is_err = 1;
    is_tmo = 1;
  endtask

  // driver: starts in an IDLE cycle, leaves in the IDLE cycle after the response.
  task automatic run_txn(input logic [NS-1:0] en, input logic we);
    int resp;
    int sel;
    bit is_err;
    bit is_tmo;
    logic [NS-1:0] exp_stb;
    predict(en, resp, is_err, is_tmo, sel);
    exp_stb = '0;
    if (sel >= 0) exp_stb[sel] = 1'b1;
    if (!is_err && !we) exp_q.push_back((sel < 0) ? DFLT : sd[sel]);
    for (int i = 0; i < NS; i++) bus.s_dat_i[i*DW +: DW] = sd[i];
    bus.m_cyc = 1'b1;
    bus.m_stb = 1'b1;
    bus.m_we = we;
    bus.s_en = en;
    bus.s_ack = '0;
    bus.s_err = '0;
    @(posedge clkcpu); #1;
    for (int c = 1; c <= resp; c++) begin
      if (c < resp) begin
        drive_slaves(c);
        bus.s_en = NS'($urandom);
      end else begin
        bus.s_ack = '0;
        bus.s_err = '0;
        bus.m_cyc = 1'b0;
        bus.m_stb = 1'b0;
      end
      @(negedge clkcpu);
      check("s_stb", bus.s_stb, (c < resp) ? exp_stb : {NS{1'b0}});
      check("s_cyc", bus.s_cyc, (c < resp) ? exp_stb : {NS{1'b0}});
      check("m_ack", bus.m_ack, (c == resp) && !is_err);
      check("m_err", bus.m_err, (c == resp) && is_err);
      check("s_we", bus.s_we, we);
      if (c == resp) begin
        if (exp_q.size() > 0) exp_dat = exp_q.pop_front();
        if (is_tmo && exp_tmo != 8'hFF) exp_tmo++;
        check("m_dat_o", bus.m_dat_o, exp_dat);
        check("tmo_count", tmo_count, exp_tmo);
      end
      @(posedge clkcpu); #1;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.m_cyc = 1'b0;
    bus.m_stb = 1'b0;
    bus.m_we = 1'b0;
    bus.s_en = '0;
    bus.s_dat_i = '0;
    bus.s_ack = '0;
    bus.s_err = '0;
    for (int i = 0; i < NS; i++) sd[i] = '0;
    clear_slaves();
    exp_dat = '0;
    exp_tmo = '0;

    repeat (3) @(posedge clkcpu);
    #1 rst_i = 1'b0;
    @(negedge clkcpu);
    check("rst_m_ack", bus.m_ack, 1'b0);
    check("rst_m_err", bus.m_err, 1'b0);
    check("rst_m_dat_o", bus.m_dat_o, 32'h0);
    check("rst_s_stb", bus.s_stb, 6'b0);
    check("rst_s_cyc", bus.s_cyc, 6'b0);
    check("rst_s_we", bus.s_we, 1'b0);
    check("rst_tmo_count", tmo_count, 8'd0);
    @(posedge clkcpu); #1;

    // slave 1 acks in cycle 2
    sd[1] = 32'h0000_00A5;
    ack_cyc[1] = 2;
    run_txn(6'b000010, 1'b0);
    // auto-acked slave 0, then unmapped read
    clear_slaves();
    sd[0] = 32'h0000_1234;
    run_txn(6'b000001, 1'b0);
    run_txn(6'b000000, 1'b0);
    // two enables: lowest wins even though slave 4 acks earlier
    sd[2] = 32'hCAFE_0002;
    sd[4] = 32'hDEAD_0004;
    ack_cyc[2] = 2;
    ack_cyc[4] = 1;
    run_txn(6'b010100, 1'b0);
    // timeout on slave 3
    clear_slaves();
    run_txn(6'b001000, 1'b0);
    check("tmo_first", tmo_count, 8'd1);
    // error and ack together: error wins
    ack_cyc[2] = 2;
    err_cyc[2] = 2;
    run_txn(6'b000100, 1'b0);
    // write leaves read data untouched
    clear_slaves();
    sd[5] = 32'h5555_AAAA;
    ack_cyc[5] = 1;
    run_txn(6'b100000, 1'b1);
    run_txn(6'b000000, 1'b1);

    // abort: m_cyc dropped in cycle 2
    clear_slaves();
    bus.m_cyc = 1'b1;
    bus.m_stb = 1'b1;
    bus.m_we = 1'b0;
    bus.s_en = 6'b000010;
    @(posedge clkcpu); #1;
    @(negedge clkcpu);
    check("abort_stb_c1", bus.s_stb, 6'b000010);
    @(posedge clkcpu); #1;
    bus.m_cyc = 1'b0;
    bus.m_stb = 1'b0;
    @(negedge clkcpu);
    check("abort_stb_c2", bus.s_stb, 6'b000010);
    for (int k = 0; k < 3; k++) begin
      @(posedge clkcpu); #1;
      @(negedge clkcpu);
      check("abort_stb_after", bus.s_stb, 6'b0);
      check("abort_ack", bus.m_ack, 1'b0);
      check("abort_err", bus.m_err, 1'b0);
    end
    @(posedge clkcpu); #1;
    sd[1] = 32'h0BAD_F00D;
    ack_cyc[1] = 1;
    run_txn(6'b000010, 1'b0);

    // randomized transactions
    for (int n = 0; n < 200; n++) begin
      for (int i = 0; i < NS; i++) begin
        sd[i] = $urandom;
        ack_cyc[i] = $urandom_range(0, 6);
        err_cyc[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
      end
      run_txn(($urandom_range(0, 4) == 0) ? 6'b0 : NS'($urandom_range(1, 63)),
              1'($urandom_range(0, 1)));
    end

    // timeout counter saturation
    clear_slaves();
    for (int n = 0; n < 300; n++) run_txn(6'b001000, 1'b0);
    check("tmo_saturated", tmo_count, 8'd255);

    // reset pulsed during BUSY of a write
    bus.m_cyc = 1'b1;
    bus.m_stb = 1'b1;
    bus.m_we = 1'b1;
    bus.s_en = 6'b001000;
    @(posedge clkcpu); #1;
    @(posedge clkcpu); #1;
    rst_i = 1'b1;
    @(negedge clkcpu);
    check("pre_rst_s_we", bus.s_we, 1'b1);
    @(posedge clkcpu); #1;
    rst_i = 1'b0;
    bus.m_cyc = 1'b0;
    bus.m_stb = 1'b0;
    @(negedge clkcpu);
    exp_dat = '0;
    exp_tmo = '0;
    check("mid_rst_m_ack", bus.m_ack, 1'b0);
    check("mid_rst_m_err", bus.m_err, 1'b0);
    check("mid_rst_m_dat_o", bus.m_dat_o, exp_dat);
    check("mid_rst_s_stb", bus.s_stb, 6'b0);
    check("mid_rst_s_cyc", bus.s_cyc, 6'b0);
    check("mid_rst_s_we", bus.s_we, 1'b0);
    check("mid_rst_tmo", tmo_count, exp_tmo);
    @(posedge clkcpu); #1;
    @(negedge clkcpu);
    check("post_rst_ack", bus.m_ack, 1'b0);
    check("post_rst_err", bus.m_err, 1'b0);
    @(posedge clkcpu); #1;
    sd[3] = 32'h3333_0003;
    ack_cyc[3] = 3;
    run_txn(6'b001000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_slave_mux.md
# wb_slave_mux

Parametrised wishbone slave multiplexer and response sequencer between the A23 CPU bus and the IO-space peripherals (IOC, FDC, latches, podules, RAM path). It generalises the fixed priority read-data mux into a registered N-slave interconnect that:
- routes one CPU cycle to exactly one slave;
- generates acks for slaves that have none;
- returns a default pattern for unmapped space;
- terminates hung cycles with an error after a programmable timeout.

## Interface

Parameters:
- NSLAVES, 6, number of slave ports (1..16)
- DW, 32, data width
- AUTO_ACK, 6'b000000, bit i set: slave i has no ack, mux acks it one cycle after strobe
- TIMEOUT, 63, cycles in BUSY before forced error (1..255)
- DEFAULT_DATA, 32'hFFFF_FFFF, read data returned when no slave is selected

Ports (one clock; reset is synchronous and active-high):
- clkcpu  in  1  CPU clock, all logic on rising edge
- rst_i  in  1  synchronous active-high reset
- m_cyc  in  1  master cycle
- m_stb  in  1  master strobe
- m_we  in  1  master write
- m_dat_o  out  DW  registered read data to CPU
- m_ack  out  1  one-cycle acknowledge
- m_err  out  1  one-cycle error (slave error or timeout)
- s_en  in  NSLAVES  decoded slave selects, sampled at cycle start
- s_cyc  out  NSLAVES  per-slave cycle, one-hot or zero
- s_stb  out  NSLAVES  per-slave strobe, one-hot or zero
- s_we  out  1  write, copy of latched m_we
- s_dat_i  in  NSLAVES*DW  slave read data, slave i at bits [i*DW +: DW]
- s_ack  in  NSLAVES  slave acks (ignored for AUTO_ACK bits)
- s_err  in  NSLAVES  slave errors
- tmo_count  out  8  saturating count of timeouts since reset

## Operation

States: IDLE, BUSY, DFLT, RESP.

- IDLE
  - On m_cyc&m_stb, latch m_we and the selected index: the lowest set bit of s_en.
  - s_en nonzero -> BUSY, clear the timeout counter.
  - s_en zero -> DFLT.
- BUSY
  - s_cyc/s_stb[sel] = 1, all other bits 0.
  - Termination priority, checked in this order each cycle:
    1. m_cyc low: abort. Go to IDLE; no ack, no err; slave strobes drop next cycle.
    2. s_err[sel]: go to RESP with err.
    3. Ack: s_ack[sel], or for an AUTO_ACK slave the second BUSY cycle. Capture s_dat_i[sel] into m_dat_o (reads only; writes leave m_dat_o unchanged) and go to RESP with ack.
    4. Counter == TIMEOUT-1: go to RESP with err, and increment tmo_count (saturating at 255).
  - Otherwise the counter increments.
- DFLT: load DEFAULT_DATA into m_dat_o on reads, then go to RESP with ack.
- RESP: exactly one of m_ack or m_err is high for this cycle. Strobes are low. Next state is IDLE.
- Back-to-back: a new cycle is accepted only in IDLE, so there is at least one idle cycle between transactions. m_stb still high in IDLE starts the next transaction.
- Multiple s_en bits set: the lowest index wins, and no other slave sees a strobe.
- s_en changing during BUSY is ignored; the index stays latched.

## Timing

- Reset values: m_ack=0, m_err=0, m_dat_o=0, s_cyc=0, s_stb=0, s_we=0, tmo_count=0, state IDLE, counter 0.
- Reset asserted mid-transaction forces the reset values on the next edge. No ack or err is emitted.
- Cycle numbering:
  - Cycle 0: m_stb sampled in IDLE.
  - Cycle 1: s_stb asserted.
  - Slave acks in cycle k≥1 -> m_ack and valid m_dat_o in cycle k+1.
- AUTO_ACK slave: s_stb in cycles 1-2, m_ack in cycle 3.
- Unmapped access: m_ack in cycle 2 with DEFAULT_DATA.
- Timeout: with no ack, m_err in cycle TIMEOUT+1 and s_stb low from that cycle.
- m_dat_o holds its value until the next captured read.

## Test plan

- s_en=6'b000010, read, slave 1 drives 32'h0000_00A5 and acks in cycle 2 -> s_stb=6'b000010 in cycles 1-2, m_ack in cycle 3, m_dat_o=32'h0000_00A5, m_err never high.
- AUTO_ACK=6'b000001, s_en=6'b000001, read with slave data 32'h1234 -> m_ack in cycle 3, m_dat_o=32'h1234. With s_en=0, read -> m_ack in cycle 2, m_dat_o=32'hFFFF_FFFF.
- s_en=6'b010100, slave 2 acks -> only s_stb[2] ever high; s_stb[4]=0 throughout; slave 2 data returned.
- TIMEOUT=4, s_en=6'b001000, slave never acks -> m_err in cycle 5, s_stb low from cycle 5, tmo_count=1. Repeat 300 times -> tmo_count stays at 255.
- Abort and reset:
  - m_cyc dropped in cycle 2 of a BUSY cycle -> no ack or err; IDLE in cycle 3; next transaction serviced normally.
  - rst_i pulsed in BUSY -> all outputs 0 next cycle.
  - s_err[sel] asserted in the same cycle as s_ack[sel] -> m_err=1, m_ack=0.
